// File: rtl/alu_control_seq.sv
// ALU control decoder with multi-cycle MULTU/DIVU sequencing.
// Decodes R-type funct into registered ALU/shifter/MDU/writeback control and stalls decode while the MDU iterates.
module alu_control_seq #(
   parameter int unsigned WIDTH      = 32,
   parameter bit          ENABLE_DIV = 1'b1,
   localparam int unsigned CNT_W     = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       funct,
   input  logic             valid,
   output logic             stall,
   output logic [5:0]       alu_ctrl,
   output logic [5:0]       sht_ctrl,
   output logic [5:0]       mdu_ctrl,
   output logic             mdu_step,
   output logic [CNT_W-1:0] iter,
   output logic [1:0]       mux_sel,
   output logic             hilo_we,
   output logic             illegal
);

   localparam logic [5:0] F_AND   = 6'd36;
   localparam logic [5:0] F_OR    = 6'd37;
   localparam logic [5:0] F_ADD   = 6'd32;
   localparam logic [5:0] F_SUB   = 6'd34;
   localparam logic [5:0] F_SLT   = 6'd42;
   localparam logic [5:0] F_SLL   = 6'd0;
   localparam logic [5:0] F_MULTU = 6'd25;
   localparam logic [5:0] F_DIVU  = 6'd27;
   localparam logic [5:0] F_MFHI  = 6'd16;
   localparam logic [5:0] F_MFLO  = 6'd18;

   localparam logic [1:0] MUX_ALU = 2'd0;
   localparam logic [1:0] MUX_SHT = 2'd1;
   localparam logic [1:0] MUX_HI  = 2'd2;
   localparam logic [1:0] MUX_LO  = 2'd3;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_WB   = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [5:0]       alu_d;
   logic [5:0]       sht_d;
   logic [5:0]       mdu_d;
   logic             step_d;
   logic [CNT_W-1:0] iter_d;
   logic [1:0]       mux_d;
   logic             hilo_d;
   logic             ill_d;
   logic             is_mdu_op;
   logic             accept;

   // MDU start is only possible from IDLE; stall covers the accept cycle and every RUN cycle.
   always_comb begin
      is_mdu_op = (funct == F_MULTU) || ((funct == F_DIVU) && ENABLE_DIV);
      accept    = (state_q == S_IDLE) && valid && is_mdu_op;
      stall     = accept || (state_q == S_RUN);
   end

   always_comb begin
      state_d = state_q;
      alu_d   = '0;
      sht_d   = '0;
      mdu_d   = '0;
      step_d  = 1'b0;
      iter_d  = '0;
      mux_d   = MUX_ALU;
      hilo_d  = 1'b0;
      ill_d   = 1'b0;
      case (state_q)
         S_IDLE, S_WB: begin
            // WB falls through to IDLE while decoding the instruction presented during the write cycle.
            state_d = S_IDLE;
            if (accept) begin
               mdu_d   = funct;
               step_d  = 1'b1;
               state_d = S_RUN;
            end else if (valid) begin
               case (funct)
                  F_AND, F_OR, F_ADD, F_SUB, F_SLT: alu_d = funct;
                  F_SLL: begin
                     sht_d = funct;
                     mux_d = MUX_SHT;
                  end
                  F_MFHI:  mux_d = MUX_HI;
                  F_MFLO:  mux_d = MUX_LO;
                  F_MULTU: ill_d = 1'b0;
                  F_DIVU:  ill_d = ~ENABLE_DIV;
                  default: ill_d = 1'b1;
               endcase
            end
         end
         S_RUN: begin
            mdu_d  = mdu_ctrl;
            step_d = 1'b1;
            iter_d = iter + CNT_W'(1);
            if (iter == LAST_ITER) begin
               state_d = S_WB;
               mdu_d   = '0;
               step_d  = 1'b0;
               iter_d  = '0;
               hilo_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         alu_ctrl <= '0;
         sht_ctrl <= '0;
         mdu_ctrl <= '0;
         mdu_step <= 1'b0;
         iter     <= '0;
         mux_sel  <= MUX_ALU;
         hilo_we  <= 1'b0;
         illegal  <= 1'b0;
      end else begin
         state_q  <= state_d;
         alu_ctrl <= alu_d;
         sht_ctrl <= sht_d;
         mdu_ctrl <= mdu_d;
         mdu_step <= step_d;
         iter     <= iter_d;
         mux_sel  <= mux_d;
         hilo_we  <= hilo_d;
         illegal  <= ill_d;
      end
   end

endmodule

// File: tb/tb_alu_control_seq.sv
// Bench for alu_control_seq: three instances (W=32 with DIVU, W=8 with DIVU, W=8 without DIVU) on shared inputs.
module tb_alu_control_seq;

   localparam int unsigned W32 = 32;
   localparam int unsigned W8  = 8;
   localparam int unsigned CW32 = $clog2(W32) + 1;
   localparam int unsigned CW8  = $clog2(W8) + 1;

   localparam logic [5:0] F_AND   = 6'd36;
   localparam logic [5:0] F_OR    = 6'd37;
   localparam logic [5:0] F_ADD   = 6'd32;
   localparam logic [5:0] F_SUB   = 6'd34;
   localparam logic [5:0] F_SLT   = 6'd42;
   localparam logic [5:0] F_SLL   = 6'd0;
   localparam logic [5:0] F_MULTU = 6'd25;
   localparam logic [5:0] F_DIVU  = 6'd27;
   localparam logic [5:0] F_MFHI  = 6'd16;
   localparam logic [5:0] F_MFLO  = 6'd18;

   typedef struct packed {
      logic [5:0] alu;
      logic [5:0] sht;
      logic [5:0] mdu;
      logic       step;
      logic [5:0] iter;
      logic [1:0] mux;
      logic       hilo;
      logic       ill;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] funct = '0;
   logic       valid = 1'b0;

   logic            a_stall, a_step, a_hilo, a_ill;
   logic [5:0]      a_alu, a_sht, a_mdu;
   logic [CW32-1:0] a_iter;
   logic [1:0]      a_mux;
   logic            b_stall, b_step, b_hilo, b_ill;
   logic [5:0]      b_alu, b_sht, b_mdu;
   logic [CW8-1:0]  b_iter;
   logic [1:0]      b_mux;
   logic            c_stall, c_step, c_hilo, c_ill;
   logic [5:0]      c_alu, c_sht, c_mdu;
   logic [CW8-1:0]  c_iter;
   logic [1:0]      c_mux;

   int   total = 0;
   int   bad = 0;
   obs_t exp_q[$];

   always #5 clk = ~clk;

   alu_control_seq #(.WIDTH(W32), .ENABLE_DIV(1'b1)) u_a (
      .clk(clk), .rst_n(rst_n), .funct(funct), .valid(valid), .stall(a_stall),
      .alu_ctrl(a_alu), .sht_ctrl(a_sht), .mdu_ctrl(a_mdu), .mdu_step(a_step),
      .iter(a_iter), .mux_sel(a_mux), .hilo_we(a_hilo), .illegal(a_ill));

   alu_control_seq #(.WIDTH(W8), .ENABLE_DIV(1'b1)) u_b (
      .clk(clk), .rst_n(rst_n), .funct(funct), .valid(valid), .stall(b_stall),
      .alu_ctrl(b_alu), .sht_ctrl(b_sht), .mdu_ctrl(b_mdu), .mdu_step(b_step),
      .iter(b_iter), .mux_sel(b_mux), .hilo_we(b_hilo), .illegal(b_ill));

   alu_control_seq #(.WIDTH(W8), .ENABLE_DIV(1'b0)) u_c (
      .clk(clk), .rst_n(rst_n), .funct(funct), .valid(valid), .stall(c_stall),
      .alu_ctrl(c_alu), .sht_ctrl(c_sht), .mdu_ctrl(c_mdu), .mdu_step(c_step),
      .iter(c_iter), .mux_sel(c_mux), .hilo_we(c_hilo), .illegal(c_ill));

   function automatic obs_t sample(input int sel);
      obs_t o;
      case (sel)
         0: begin
            o.alu = a_alu; o.sht = a_sht; o.mdu = a_mdu; o.step = a_step;
            o.iter = 6'(a_iter); o.mux = a_mux; o.hilo = a_hilo; o.ill = a_ill;
         end
         1: begin
            o.alu = b_alu; o.sht = b_sht; o.mdu = b_mdu; o.step = b_step;
            o.iter = 6'(b_iter); o.mux = b_mux; o.hilo = b_hilo; o.ill = b_ill;
         end
         default: begin
            o.alu = c_alu; o.sht = c_sht; o.mdu = c_mdu; o.step = c_step;
            o.iter = 6'(c_iter); o.mux = c_mux; o.hilo = c_hilo; o.ill = c_ill;
         end
      endcase
      return o;
   endfunction

   function automatic logic get_stall(input int sel);
      case (sel)
         0:       return a_stall;
         1:       return b_stall;
         default: return c_stall;
      endcase
   endfunction

   function automatic obs_t mk(input logic [5:0] alu, input logic [5:0] sht, input logic [5:0] mdu,
                               input logic step, input int it, input logic [1:0] mux,
                               input logic hilo, input logic ill);
      obs_t o;
      o.alu = alu; o.sht = sht; o.mdu = mdu; o.step = step;
      o.iter = 6'(it); o.mux = mux; o.hilo = hilo; o.ill = ill;
      return o;
   endfunction

   task automatic do_reset;
      @(negedge clk);
      rst_n = 1'b0;
      valid = 1'b0;
      funct = '0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      obs_t o, e;
      do_reset();
      for (int s = 0; s < 3; s++) begin
         o = sample(s);
         total++;
         if (o !== '0) begin bad++; $display("FAIL reset_state dut=%0d got=%h exp=0", s, o); end
         total++;
         if (get_stall(s) !== 1'b0) begin bad++; $display("FAIL reset_stall dut=%0d got=%b exp=0", s, get_stall(s)); end
      end
      // Put the W=32 instance into RUN, then pull reset between edges.
      @(posedge clk); #1 funct = F_MULTU; valid = 1'b1;
      @(posedge clk); #1 valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      e = mk(6'd0, 6'd0, F_MULTU, 1'b1, 2, 2'd0, 1'b0, 1'b0);
      o = sample(0);
      total++;
      if (o !== e) begin bad++; $display("FAIL pre_reset_run got=%h exp=%h", o, e); end
      #2 rst_n = 1'b0;
      #1;
      o = sample(0);
      total++;
      if (o !== '0) begin bad++; $display("FAIL async_reset got=%h exp=0", o); end
      total++;
      if (a_stall !== 1'b0) begin bad++; $display("FAIL async_reset_stall got=%b exp=0", a_stall); end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1 funct = F_ADD; valid = 1'b1;
      exp_q.push_back(mk(F_ADD, 6'd0, 6'd0, 1'b0, 0, 2'd0, 1'b0, 1'b0));
      @(posedge clk); #1 valid = 1'b0;
      e = exp_q.pop_front();
      o = sample(0);
      total++;
      if (o !== e) begin bad++; $display("FAIL add_after_reset got=%h exp=%h", o, e); end
   endtask

   task automatic test_decode;
      logic [5:0] fs [10];
      logic       vs [10];
      obs_t       ex [10];
      obs_t       o, e;
      fs = '{F_AND, F_OR, F_SUB, F_SLT, F_SLL, F_MFHI, F_MFLO, 6'b000111, F_ADD, F_ADD};
      vs = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      ex[0] = mk(6'd36, 6'd0, 6'd0, 1'b0, 0, 2'd0, 1'b0, 1'b0);
      ex[1] = mk(6'd37, 6'd0, 6'd0, 1'b0, 0, 2'd0, 1'b0, 1'b0);
      ex[2] = mk(6'd34, 6'd0, 6'd0, 1'b0, 0, 2'd0, 1'b0, 1'b0);
      ex[3] = mk(6'd42, 6'd0, 6'd0, 1'b0, 0, 2'd0, 1'b0, 1'b0);
      ex[4] = mk(6'd0,  6'd0, 6'd0, 1'b0, 0, 2'd1, 1'b0, 1'b0);
      ex[5] = mk(6'd0,  6'd0, 6'd0, 1'b0, 0, 2'd2, 1'b0, 1'b0);
      ex[6] = mk(6'd0,  6'd0, 6'd0, 1'b0, 0, 2'd3, 1'b0, 1'b0);
      ex[7] = mk(6'd0,  6'd0, 6'd0, 1'b0, 0, 2'd0, 1'b0, 1'b1);
      ex[8] = '0;
      ex[9] = '0;
      do_reset();
      for (int i = 0; i < 11; i++) begin
         @(posedge clk); #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = sample(0);
            total++;
            if (o !== e) begin bad++; $display("FAIL decode idx=%0d got=%h exp=%h", i - 1, o, e); end
         end
         if (i < 10) begin
            funct = fs[i];
            valid = vs[i];
            exp_q.push_back(ex[i]);
         end
         @(negedge clk);
         total++;
         if (a_stall !== 1'b0) begin bad++; $display("FAIL decode_stall idx=%0d got=%b exp=0", i, a_stall); end
      end
   endtask

   task automatic test_multu;
      obs_t o, e;
      int   stall_cnt = 0, step_cnt = 0, pulses = 0, pulse_c = -1;
      logic exp_stall;
      do_reset();
      for (int c = 0; c < int'(W32) + 4; c++) begin
         @(posedge clk); #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = sample(0);
            total++;
            if (o !== e) begin bad++; $display("FAIL multu c=%0d got=%h exp=%h", c, o, e); end
            if (o.hilo) begin pulses++; pulse_c = c; end
            if (o.step) step_cnt++;
         end
         if (c == 0) begin
            funct = F_MULTU; valid = 1'b1;
            exp_q.push_back(mk(6'd0, 6'd0, F_MULTU, 1'b1, 0, 2'd0, 1'b0, 1'b0));
         end else if (c < int'(W32)) begin
            funct = F_ADD; valid = 1'b1;   // ignored while running
            exp_q.push_back(mk(6'd0, 6'd0, F_MULTU, 1'b1, c, 2'd0, 1'b0, 1'b0));
         end else if (c == int'(W32)) begin
            funct = 6'b000111; valid = 1'b1;
            exp_q.push_back(mk(6'd0, 6'd0, 6'd0, 1'b0, 0, 2'd0, 1'b1, 1'b0));
         end else if (c == int'(W32) + 1) begin
            funct = F_MFHI; valid = 1'b1;  // presented during WB, decoded on return to IDLE
            exp_q.push_back(mk(6'd0, 6'd0, 6'd0, 1'b0, 0, 2'd2, 1'b0, 1'b0));
         end else begin
            valid = 1'b0;
            exp_q.push_back('0);
         end
         @(negedge clk);
         exp_stall = (c <= int'(W32));
         total++;
         if (a_stall !== exp_stall) begin bad++; $display("FAIL multu_stall c=%0d got=%b exp=%b", c, a_stall, exp_stall); end
         if (a_stall) stall_cnt++;
      end
      total++;
      if (stall_cnt != int'(W32) + 1) begin bad++; $display("FAIL multu_stall_len got=%0d exp=%0d", stall_cnt, W32 + 1); end
      total++;
      if (step_cnt != int'(W32)) begin bad++; $display("FAIL multu_step_len got=%0d exp=%0d", step_cnt, W32); end
      total++;
      if (pulses != 1 || pulse_c != int'(W32) + 1) begin
         bad++; $display("FAIL multu_pulse count=%0d at=%0d exp count=1 at=%0d", pulses, pulse_c, W32 + 1);
      end
   endtask

   task automatic test_back_to_back;
      obs_t o, e;
      int   p_first = -1, p_second = -1, pulses = 0;
      int   w = int'(W8);
      logic exp_stall;
      do_reset();
      for (int c = 0; c < 2 * w + 5; c++) begin
         @(posedge clk); #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = sample(1);
            total++;
            if (o !== e) begin bad++; $display("FAIL b2b c=%0d got=%h exp=%h", c, o, e); end
            if (o.hilo) begin
               pulses++;
               if (p_first < 0) p_first = c; else p_second = c;
            end
         end
         if (c == 0) begin
            funct = F_DIVU; valid = 1'b1;
            exp_q.push_back(mk(6'd0, 6'd0, F_DIVU, 1'b1, 0, 2'd0, 1'b0, 1'b0));
         end else if (c < w) begin
            valid = 1'b0;
            exp_q.push_back(mk(6'd0, 6'd0, F_DIVU, 1'b1, c, 2'd0, 1'b0, 1'b0));
         end else if (c == w || c == 2 * w + 2) begin
            valid = 1'b0;
            exp_q.push_back(mk(6'd0, 6'd0, 6'd0, 1'b0, 0, 2'd0, 1'b1, 1'b0));
         end else if (c == w + 2) begin
            funct = F_MULTU; valid = 1'b1;
            exp_q.push_back(mk(6'd0, 6'd0, F_MULTU, 1'b1, 0, 2'd0, 1'b0, 1'b0));
         end else if (c > w + 2 && c < 2 * w + 2) begin
            valid = 1'b0;
            exp_q.push_back(mk(6'd0, 6'd0, F_MULTU, 1'b1, c - (w + 2), 2'd0, 1'b0, 1'b0));
         end else begin
            valid = 1'b0;
            exp_q.push_back('0);
         end
         @(negedge clk);
         exp_stall = (c <= w) || (c >= w + 2 && c <= 2 * w + 2);
         total++;
         if (b_stall !== exp_stall) begin bad++; $display("FAIL b2b_stall c=%0d got=%b exp=%b", c, b_stall, exp_stall); end
      end
      total++;
      if (pulses != 2 || p_first != w + 1 || p_second != p_first + w + 2) begin
         bad++;
         $display("FAIL b2b_pulses count=%0d first=%0d second=%0d exp count=2 first=%0d second=%0d",
                  pulses, p_first, p_second, w + 1, 2 * w + 3);
      end
   endtask

   task automatic test_no_div;
      obs_t o, e;
      do_reset();
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = sample(2);
            total++;
            if (o !== e) begin bad++; $display("FAIL nodiv c=%0d got=%h exp=%h", c, o, e); end
         end
         if (c == 0) begin
            funct = F_DIVU; valid = 1'b1;
            exp_q.push_back(mk(6'd0, 6'd0, 6'd0, 1'b0, 0, 2'd0, 1'b0, 1'b1));
         end else if (c < 3) begin
            valid = 1'b0;
            exp_q.push_back('0);
         end
         @(negedge clk);
         total++;
         if (c_stall !== 1'b0) begin bad++; $display("FAIL nodiv_stall c=%0d got=%b exp=0", c, c_stall); end
      end
   endtask

   task automatic test_reset_mid_run;
      obs_t o, e;
      int   pulses = 0;
      do_reset();
      for (int c = 0; c < 19; c++) begin
         @(posedge clk); #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = sample(0);
            total++;
            if (o !== e) begin bad++; $display("FAIL midrun c=%0d got=%h exp=%h", c, o, e); end
         end
         if (c == 0) begin
            funct = F_MULTU; valid = 1'b1;
            exp_q.push_back(mk(6'd0, 6'd0, F_MULTU, 1'b1, 0, 2'd0, 1'b0, 1'b0));
         end else if (c < 18) begin
            valid = 1'b0;
            exp_q.push_back(mk(6'd0, 6'd0, F_MULTU, 1'b1, c, 2'd0, 1'b0, 1'b0));
         end else begin
            valid = 1'b0;
         end
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      o = sample(0);
      total++;
      if (o !== '0) begin bad++; $display("FAIL midrun_reset got=%h exp=0", o); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < int'(W32) + 6; c++) begin
         @(negedge clk);
         if (a_hilo) pulses++;
      end
      o = sample(0);
      total++;
      if (o !== '0) begin bad++; $display("FAIL midrun_idle got=%h exp=0", o); end
      total++;
      if (a_stall !== 1'b0) begin bad++; $display("FAIL midrun_stall got=%b exp=0", a_stall); end
      total++;
      if (pulses != 0) begin bad++; $display("FAIL midrun_hilo got=%0d pulses exp=0", pulses); end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_decode();
      test_multu();
      test_back_to_back();
      test_no_div();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
